glyph_renderer: RTL

- Sequential, parametrised successor to the combinational letter display.
- Renders NUM_LETTERS glyph bitmaps, each at its own vertical position, into a back buffer: clear pass, then row-by-row draw pass.
- Copies the back buffer to the output framebuffer in one atomic swap, so the VGA/scan-out side never sees a partially drawn frame.
- Glyph bitmaps come from the existing letter lookup logic (one per letter), fed in packed.

---
 rtl/glyph_renderer_if.sv | 32 +++
 rtl/glyph_renderer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/glyph_renderer_if.sv
// Glyph renderer bus: render request with its letter data, and the status/frame coming back.
//   start       - request a render (master -> slave)
//   ypos        - per-letter y positions, letter k at [k*YW +: YW]
//   glyphs      - per-letter bitmaps, letter k at [k*GLYPH_W*GLYPH_H +: GLYPH_W*GLYPH_H]
//   busy        - render in progress (slave -> master)
//   done        - one-cycle pulse when framebuffer is updated
//   framebuffer - displayed frame, pixel (row,col) at bit row*FB_W+col
interface glyph_renderer_if #(
    parameter int unsigned FB_W        = 40,
    parameter int unsigned FB_H        = 30,
    parameter int unsigned NUM_LETTERS = 3,
    parameter int unsigned GLYPH_W     = 6,
    parameter int unsigned GLYPH_H     = 5,
    parameter int unsigned YW          = 5
);
    logic                                   start;
    logic [NUM_LETTERS*YW-1:0]              ypos;
    logic [NUM_LETTERS*GLYPH_W*GLYPH_H-1:0] glyphs;
    logic                                   busy;
    logic                                   done;
    logic [FB_W*FB_H-1:0]                   framebuffer;

    modport master (
        output start, ypos, glyphs,
        input  busy, done, framebuffer
    );

    modport slave (
        input  start, ypos, glyphs,
        output busy, done, framebuffer
    );
endinterface

// File: rtl/glyph_renderer.sv
// Glyph renderer: snapshots NUM_LETTERS glyph bitmaps and their y positions, clears a back
// buffer row by row, ORs each glyph row into place (rows falling below the frame are dropped),
// then copies the back buffer to the displayed framebuffer in a single edge.
//   clock - rising-edge clock
//   reset - asynchronous active-high reset; aborts any render in progress
//   bus   - glyph_renderer_if slave: start/ypos/glyphs in, busy/done/framebuffer out
module glyph_renderer #(
    parameter int unsigned FB_W        = 40,
    parameter int unsigned FB_H        = 30,
    parameter int unsigned NUM_LETTERS = 3,
    parameter int unsigned GLYPH_W     = 6,
    parameter int unsigned GLYPH_H     = 5,
    parameter int unsigned YW          = 5,
    parameter int unsigned X0          = 6,
    parameter int unsigned X_PITCH     = 10,
    parameter int unsigned Y_OFFSET    = 2
) (
    input logic             clock,
    input logic             reset,
    glyph_renderer_if.slave bus
);
    localparam int unsigned GLYPH_BITS = GLYPH_W * GLYPH_H;
    localparam int unsigned ROW_W      = (FB_H > 1) ? $clog2(FB_H) : 1;
    localparam int unsigned LET_W      = (NUM_LETTERS > 1) ? $clog2(NUM_LETTERS) : 1;
    localparam int unsigned GROW_W     = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
    // Target row width chosen so Y_OFFSET + ypos + r never wraps.
    localparam int unsigned TW         = YW + 3;

    if (X0 + (NUM_LETTERS - 1) * X_PITCH + GLYPH_W > FB_W) begin : g_fit_check
        $fatal(1, "glyph_renderer: letters do not fit horizontally in FB_W");
    end
    if (ROW_W > TW) begin : g_row_check
        $fatal(1, "glyph_renderer: YW too narrow to address every framebuffer row");
    end

    typedef enum logic [1:0] {StIdle, StClear, StDraw, StSwap} state_e;

    state_e                                   state_q;
    logic [NUM_LETTERS-1:0][YW-1:0]           ypos_q;
    logic [NUM_LETTERS-1:0][GLYPH_BITS-1:0]   glyphs_q;
    logic [FB_H-1:0][FB_W-1:0]                back_q;
    logic [FB_H-1:0][FB_W-1:0]                fb_q;
    logic [ROW_W-1:0]                         row_q;
    logic [LET_W-1:0]                         letter_q;
    logic [GROW_W-1:0]                        grow_q;
    logic                                     busy_q;
    logic                                     done_q;

    logic [GLYPH_W-1:0] glyph_row;
    logic [TW-1:0]      target;
    logic               target_ok;
    logic [ROW_W-1:0]   target_idx;
    logic [FB_W-1:0]    draw_mask;

    // Current glyph row placed at its letter's column offset, and where it lands vertically.
    always_comb begin
        glyph_row  = glyphs_q[letter_q][(GLYPH_H - 1 - int'(grow_q)) * GLYPH_W +: GLYPH_W];
        target     = TW'(Y_OFFSET) + TW'(ypos_q[letter_q]) + TW'(grow_q);
        target_ok  = target < TW'(FB_H);
        target_idx = target[ROW_W-1:0];
        draw_mask  = FB_W'(glyph_row) << (X0 + int'(letter_q) * X_PITCH);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            ypos_q   <= '0;
            glyphs_q <= '0;
            back_q   <= '0;
            fb_q     <= '0;
            row_q    <= '0;
            letter_q <= '0;
            grow_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        ypos_q   <= bus.ypos;
                        glyphs_q <= bus.glyphs;
                        busy_q   <= 1'b1;
                        row_q    <= '0;
                        state_q  <= StClear;
                    end
                end
                StClear: begin
                    back_q[row_q] <= '0;
                    if (row_q == ROW_W'(FB_H - 1)) begin
                        row_q    <= '0;
                        letter_q <= '0;
                        grow_q   <= '0;
                        state_q  <= StDraw;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end
                StDraw: begin
                    // Clipped rows still take their cycle so latency is data independent.
                    if (target_ok) begin
                        back_q[target_idx] <= back_q[target_idx] | draw_mask;
                    end
                    if (grow_q == GROW_W'(GLYPH_H - 1)) begin
                        grow_q <= '0;
                        if (letter_q == LET_W'(NUM_LETTERS - 1)) begin
                            letter_q <= '0;
                            state_q  <= StSwap;
                        end else begin
                            letter_q <= letter_q + 1'b1;
                        end
                    end else begin
                        grow_q <= grow_q + 1'b1;
                    end
                end
                StSwap: begin
                    fb_q    <= back_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.framebuffer = fb_q;
endmodule
